reg_alu_seq: RTL and testbench
==============================

# reg_alu_seq

Register-file sequencer that sits directly upstream of the 16-bit ripple ALU (op encoding 00 add, 01 sub, 10 and, 11 or). It accepts one command at a time over a valid/ready handshake and reads two operands from an 8×16 register file. It drives the ALU's `op`/`i0`/`i1` inputs from registered operands, captures the ALU result and writes it back to a destination register. It also supports immediate loads and exposes a combinational debug read port.

## Interface
- `NREGS`, 8: register count; fixed at 8 (3-bit addresses).
- `W`, 16: datapath width; must match the ALU.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_ld` in 1: 1 = load `cmd_imm` into `cmd_rd`; 0 = ALU op.
- `cmd_op` in 2: ALU op code.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2` in 3 each: destination and sources.
- `cmd_imm` in 16: immediate value for loads.
- `alu_op` out 2: to ALU `op`.
- `alu_a` out 16: to ALU `i0`.
- `alu_b` out 16: to ALU `i1`.
- `alu_o` in 16: ALU result.
- `alu_cout` in 1: ALU carry out.
- `res_valid` out 1: one-cycle pulse; write-back done.
- `res_data` out 16: value written.
- `res_rd` out 3: register written.
- `dbg_addr` in 3: debug read address.
- `dbg_data` out 16: combinational read of `regs[dbg_addr]`.
- `carry` out 1: only present with `REG_ALU_SEQ_CARRY_EN`.

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- Reset values:
  - All registers 0.
  - `alu_op`, `alu_a`, `alu_b`, `res_data`, `res_rd` = 0.
  - `res_valid` = 0.
  - `carry` = 0.
  - `cmd_ready` = 1 (it is combinational: 1 only in IDLE).
- IDLE, `cmd_valid && cmd_ready`, with `cmd_ld=0`:
  - Latch `alu_op`←`cmd_op`, `alu_a`←`regs[rs1]`, `alu_b`←`regs[rs2]`, and `rd`.
  - Go to EXEC.
- IDLE, accepted command with `cmd_ld=1`:
  - Latch the immediate into `res_data` and `rd` into `res_rd`.
  - Go to WB.
- EXEC:
  - ALU inputs are stable for the whole cycle.
  - At the clock edge: `res_data`←`alu_o`, `res_rd`←`rd`.
  - Go to WB.
- WB:
  - `res_valid`=1.
  - At the clock edge, `regs[res_rd]`←`res_data`; go to IDLE.
- Operand reads use register contents at the acceptance edge. There is no bypass; none is needed because WB completes before the next acceptance.
- `rs1 == rs2` and `rd == rs1` are legal. The old value is read and the new value is written in WB.
- Arithmetic is modulo 2^16. Sub is a + ~b + 1 inside the ALU, so `alu_cout`=1 means no borrow.
- `alu_op`/`alu_a`/`alu_b` hold their last values outside EXEC.
- `cmd_*` inputs are ignored when `cmd_ready`=0.
- `rst_n` low in any state:
  - FSM goes to IDLE immediately.
  - Any in-flight write-back is lost; all registers are cleared.

## Timing
- ALU command accepted at edge 0: EXEC in cycle 1, WB in cycle 2 (`res_valid` high), register updated at edge 3, `cmd_ready` high again in cycle 3.
- Load command accepted at edge 0: WB in cycle 1, `cmd_ready` high in cycle 2.
- Throughput: one ALU command per 3 cycles; one load per 2 cycles.
- `dbg_data` shows the new value from the cycle after the write edge.

## Configuration
- `REG_ALU_SEQ_CARRY_EN` defined:
  - The `carry` port and flag register exist.
  - At the EXEC edge with `alu_op[1]==0`, `carry`←`alu_cout`.
  - And/or ops and loads leave `carry` unchanged.
- Undefined: no `carry` port and no flag register. `alu_cout` is left unused.

## Structure
- Shared package `alu_pkg` holds:
  - op codes `OP_ADD=2'b00`, `OP_SUB=2'b01`, `OP_AND=2'b10`, `OP_OR=2'b11`;
  - FSM state enum `seq_state_t`;
  - `W` and `NREGS`.
- One sub-module, `regfile8x16`: 8×16 flops, async clear on `rst_n`, one write port, three combinational read ports (rs1, rs2, dbg).
- The FSM and the ALU interface stay in the top module.

## Test plan
- Reset then `dbg_addr` 0..7 -> all `dbg_data`=0. `cmd_ready`=1, `res_valid`=0.
- Load r1=0x1234, r2=0x0FFF; add r3=r1+r2 -> `alu_a`=0x1234, `alu_b`=0x0FFF, `alu_op`=00 in EXEC. `res_valid` pulse with `res_data`=0x2233, `res_rd`=3. r3 reads 0x2233.
- Load r4=0x0001, r5=0x0002; sub r6=r4-r5 -> r6=0xFFFF. With CARRY_EN, `carry`=0. Then sub r7=r5-r4 -> 0x0001, `carry`=1.
- and/or with r1=0xF0F0, r2=0x3C3C -> and gives 0x3030, or gives 0xFCFC. `carry` unchanged.
- Hold `cmd_valid` high with back-to-back commands -> `cmd_ready` low in EXEC/WB and exactly one acceptance per 3 cycles. Self-update r1=r1+r1 with r1=0x8000 -> 0x0000.
- Assert `rst_n` low during EXEC -> the next cycle shows IDLE, no `res_valid`, and all registers 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the register-file ALU sequencer.
//   W      : datapath width (matches the downstream ripple ALU)
//   NREGS  : register count (3-bit addresses)
//   OP_*   : ALU op encodings
//   seq_state_t : sequencer FSM states
package alu_pkg;

  localparam int unsigned W     = 16;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StWb   = 2'b10
  } seq_state_t;

endpackage

// File: rtl/reg_alu_seq_if.sv
// Bundle of command, ALU, result and debug signals for reg_alu_seq.
//   slave  : the sequencer side (accepts commands, drives the ALU inputs)
//   master : the command source / ALU / observer side
// Macro REG_ALU_SEQ_CARRY_EN adds the carry flag output.
interface reg_alu_seq_if;
  import alu_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_ld;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [W-1:0]  cmd_imm;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_o;
  logic          alu_cout;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic [AW-1:0] res_rd;
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;
`ifdef REG_ALU_SEQ_CARRY_EN
  logic          carry;
`endif

  modport slave (
    input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  alu_o, alu_cout, dbg_addr,
`ifdef REG_ALU_SEQ_CARRY_EN
    output carry,
`endif
    output cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_rd, dbg_data
  );

  modport master (
    output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output alu_o, alu_cout, dbg_addr,
`ifdef REG_ALU_SEQ_CARRY_EN
    input  carry,
`endif
    input  cmd_ready, alu_op, alu_a, alu_b, res_valid, res_data, res_rd, dbg_data
  );

endinterface

// File: rtl/regfile8x16.sv
// 8 x 16 register file: asynchronous clear, one write port, three
// combinational read ports (two operands plus debug).
//   clk_i, rst_ni         : clock, async active-low clear
//   we_i, waddr_i, wdata_i: write port
//   ra1_i/rd1_o, ra2_i/rd2_o, ra3_i/rd3_o : read ports
module regfile8x16
  import alu_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  input  logic [AW-1:0] ra3_i,
  output logic [W-1:0]  rd1_o,
  output logic [W-1:0]  rd2_o,
  output logic [W-1:0]  rd3_o
);

  logic [W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rd1_o = regs_q[ra1_i];
  assign rd2_o = regs_q[ra2_i];
  assign rd3_o = regs_q[ra3_i];

endmodule

// File: rtl/reg_alu_seq.sv
// Register-file sequencer feeding a 16-bit ALU. Takes one command at a time
// (ALU op or immediate load), drives registered ALU operands for one EXEC
// cycle, captures the result and writes it back in WB.
//   clk, rst_n : clock, async active-low reset
//   bus        : reg_alu_seq_if.slave (command, ALU, result, debug signals)
// Macro REG_ALU_SEQ_CARRY_EN: adds a carry flag updated by add/sub.
module reg_alu_seq
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  reg_alu_seq_if.slave   bus
);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [W-1:0]  res_data_q, res_data_d;
  logic [AW-1:0] res_rd_q, res_rd_d;
  logic          carry_q, carry_d;
  logic          we;
  logic [W-1:0]  rs1_data, rs2_data;

  regfile8x16 u_regfile (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (we),
    .waddr_i (res_rd_q),
    .wdata_i (res_data_q),
    .ra1_i   (bus.cmd_rs1),
    .ra2_i   (bus.cmd_rs2),
    .ra3_i   (bus.dbg_addr),
    .rd1_o   (rs1_data),
    .rd2_o   (rs2_data),
    .rd3_o   (bus.dbg_data)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    carry_d    = carry_q;
    we         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_ld) begin
            res_data_d = bus.cmd_imm;
            res_rd_d   = bus.cmd_rd;
            state_d    = StWb;
          end else begin
            alu_op_d = bus.cmd_op;
            alu_a_d  = rs1_data;
            alu_b_d  = rs2_data;
            rd_d     = bus.cmd_rd;
            state_d  = StExec;
          end
        end
      end
      StExec: begin
        res_data_d = bus.alu_o;
        res_rd_d   = rd_q;
        // Only add/sub produce a meaningful carry.
        if (!alu_op_q[1]) carry_d = bus.alu_cout;
        state_d = StWb;
      end
      StWb: begin
        we      = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rd_q       <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      carry_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      carry_q    <= carry_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.res_valid = (state_q == StWb);
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;

`ifdef REG_ALU_SEQ_CARRY_EN
  assign bus.carry = carry_q;
`else
  // Flag register has no observer without the carry port.
  logic unused_carry;
  assign unused_carry = carry_q ^ bus.alu_cout;
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
module tb_reg_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  reg_alu_seq_if bus ();

  reg_alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 16-bit ALU driven by the DUT's operand outputs.
  logic [W:0] sum17;
  always_comb begin
    sum17 = '0;
    bus.alu_cout = 1'b0;
    case (bus.alu_op)
      OP_ADD: begin
        sum17 = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_o = sum17[W-1:0];
        bus.alu_cout = sum17[W];
      end
      OP_SUB: begin
        sum17 = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
        bus.alu_o = sum17[W-1:0];
        bus.alu_cout = sum17[W];
      end
      OP_AND: bus.alu_o = bus.alu_a & bus.alu_b;
      default: bus.alu_o = bus.alu_a | bus.alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic [1:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] exp_res;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [13];

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("v%0d", idx);
    wait_idle(nm);
    bus.cmd_valid = 1'b1;
    bus.cmd_ld    = v.ld;
    bus.cmd_op    = v.op;
    bus.cmd_rd    = v.rd;
    bus.cmd_rs1   = v.rs1;
    bus.cmd_rs2   = v.rs2;
    bus.cmd_imm   = v.imm;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({nm, "_ready_busy"}, 32'(bus.cmd_ready), 32'd0);
    if (!v.ld) begin
      check({nm, "_alu_a"}, 32'(bus.alu_a), 32'(v.exp_a));
      check({nm, "_alu_b"}, 32'(bus.alu_b), 32'(v.exp_b));
      check({nm, "_alu_op"}, 32'(bus.alu_op), 32'(v.op));
      check({nm, "_exec_no_valid"}, 32'(bus.res_valid), 32'd0);
      @(negedge clk);
    end
    check({nm, "_res_valid"}, 32'(bus.res_valid), 32'd1);
    check({nm, "_res_data"}, 32'(bus.res_data), 32'(v.exp_res));
    check({nm, "_res_rd"}, 32'(bus.res_rd), 32'(v.rd));
    bus.dbg_addr = v.rd;
    @(negedge clk);
    check({nm, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    check({nm, "_valid_pulse"}, 32'(bus.res_valid), 32'd0);
    check({nm, "_dbg_rd"}, 32'(bus.dbg_data), 32'(v.exp_res));
`ifdef REG_ALU_SEQ_CARRY_EN
    check({nm, "_carry"}, 32'(bus.carry), 32'(v.exp_carry));
`endif
  endtask

  task automatic check_all_regs(input string name, input logic [15:0] exp [8]);
    for (int r = 0; r < 8; r++) begin
      bus.dbg_addr = 3'(r);
      #1;
      check($sformatf("%s_r%0d", name, r), 32'(bus.dbg_data), 32'(exp[r]));
    end
  endtask

  initial begin
    logic [15:0] zeros [8];
    int accepts;
    checks   = 0;
    failures = 0;
    for (int r = 0; r < 8; r++) zeros[r] = 16'h0;

    //           ld  op      rd    rs1   rs2   imm       a        b        res      carry
    vecs[0]  = '{1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'h1234, 16'h0,    16'h0,    16'h1234, 1'b0};
    vecs[1]  = '{1'b1, 2'b00, 3'd2, 3'd0, 3'd0, 16'h0FFF, 16'h0,    16'h0,    16'h0FFF, 1'b0};
    vecs[2]  = '{1'b0, OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0,   16'h1234, 16'h0FFF, 16'h2233, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 3'd4, 3'd0, 3'd0, 16'h0001, 16'h0,    16'h0,    16'h0001, 1'b0};
    vecs[4]  = '{1'b1, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0002, 16'h0,    16'h0,    16'h0002, 1'b0};
    vecs[5]  = '{1'b0, OP_SUB, 3'd6, 3'd4, 3'd5, 16'h0,   16'h0001, 16'h0002, 16'hFFFF, 1'b0};
    vecs[6]  = '{1'b0, OP_SUB, 3'd7, 3'd5, 3'd4, 16'h0,   16'h0002, 16'h0001, 16'h0001, 1'b1};
    vecs[7]  = '{1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'hF0F0, 16'h0,    16'h0,    16'hF0F0, 1'b1};
    vecs[8]  = '{1'b1, 2'b00, 3'd2, 3'd0, 3'd0, 16'h3C3C, 16'h0,    16'h0,    16'h3C3C, 1'b1};
    vecs[9]  = '{1'b0, OP_AND, 3'd3, 3'd1, 3'd2, 16'h0,   16'hF0F0, 16'h3C3C, 16'h3030, 1'b1};
    vecs[10] = '{1'b0, OP_OR,  3'd4, 3'd1, 3'd2, 16'h0,   16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b1};
    vecs[11] = '{1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'h8000, 16'h0,    16'h0,    16'h8000, 1'b1};
    vecs[12] = '{1'b0, OP_ADD, 3'd1, 3'd1, 3'd1, 16'h0,   16'h8000, 16'h8000, 16'h0000, 1'b1};

    bus.cmd_valid = 1'b0;
    bus.cmd_ld    = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_rd    = '0;
    bus.cmd_rs1   = '0;
    bus.cmd_rs2   = '0;
    bus.cmd_imm   = '0;
    bus.dbg_addr  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check_all_regs("reset", zeros);
    check("reset_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_res_valid", 32'(bus.res_valid), 32'd0);
    check("reset_alu_a", 32'(bus.alu_a), 32'd0);
    check("reset_res_data", 32'(bus.res_data), 32'd0);
`ifdef REG_ALU_SEQ_CARRY_EN
    check("reset_carry", 32'(bus.carry), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // r3 kept the and result, r2 still 0x3C3C after the table.
    bus.dbg_addr = 3'd3;
    #1;
    check("r3_after_table", 32'(bus.dbg_data), 32'h3030);

    // Back-to-back: r5 = r5 + r5 with cmd_valid held; one acceptance per 3 cycles.
    wait_idle("b2b");
    bus.cmd_valid = 1'b1;
    bus.cmd_ld    = 1'b0;
    bus.cmd_op    = OP_ADD;
    bus.cmd_rd    = 3'd5;
    bus.cmd_rs1   = 3'd5;
    bus.cmd_rs2   = 3'd5;
    accepts = 0;
    for (int c = 0; c < 9; c++) begin
      if (bus.cmd_ready === 1'b1) accepts++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd3);
    check("b2b_ready_end", 32'(bus.cmd_ready), 32'd1);
    bus.dbg_addr = 3'd5;
    #1;
    check("b2b_r5", 32'(bus.dbg_data), 32'h0010);

    // Reset asserted during EXEC kills the write-back and clears everything.
    bus.cmd_valid = 1'b1;
    bus.cmd_ld    = 1'b0;
    bus.cmd_op    = OP_OR;
    bus.cmd_rd    = 3'd0;
    bus.cmd_rs1   = 3'd1;
    bus.cmd_rs2   = 3'd2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("rst_exec_busy", 32'(bus.cmd_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_no_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    check("rst_after_no_valid", 32'(bus.res_valid), 32'd0);
    check("rst_after_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check_all_regs("rst_exec", zeros);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
